// File: rtl/parity_tx.sv
// parity_tx: bit-serial even/odd parity transmitter, LSB-first, optional start/stop framing.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   i_start       send request, sampled only in IDLE
//   i_data_in     payload, captured on acceptance
//   i_odd_sel     0 = even parity, 1 = odd parity, captured on acceptance
//   o_serial_out  line output, idles high
//   o_ser_valid   high while the line carries a frame bit
//   o_parity_out  parity bit of the most recent frame, held until the next PARITY state
//   o_busy        high in every state except IDLE
//   o_done        one-cycle pulse after the last frame bit
//
// Build option: define PARITY_TX_FRAME_EN to wrap each frame in a start bit (0)
// and a stop bit (1). Without it the frame is payload followed by parity.
module parity_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic              i_odd_sel,
    output logic              o_serial_out,
    output logic              o_ser_valid,
    output logic              o_parity_out,
    output logic              o_busy,
    output logic              o_done
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef PARITY_TX_FRAME_EN
        S_START,
        S_STOP,
`endif
        S_DATA,
        S_PARITY,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_shift;
    logic              r_par_acc;
    logic [CW-1:0]     r_bit_cnt;
    logic              r_parity_out;
    logic              w_accept;

    assign w_accept = (r_state == S_IDLE) && i_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
`ifdef PARITY_TX_FRAME_EN
            S_IDLE:   w_next = i_start ? S_START : S_IDLE;
            S_START:  w_next = S_DATA;
            S_PARITY: w_next = S_STOP;
            S_STOP:   w_next = S_DONE;
`else
            S_IDLE:   w_next = i_start ? S_DATA : S_IDLE;
            S_PARITY: w_next = S_DONE;
`endif
            S_DATA:   w_next = (r_bit_cnt == LAST) ? S_PARITY : S_DATA;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // The accumulator is seeded with odd_sel, so after XOR-ing every payload
    // bit it already holds the parity bit to send for either sense.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift      <= '0;
            r_par_acc    <= 1'b0;
            r_bit_cnt    <= '0;
            r_parity_out <= 1'b0;
        end else if (w_accept) begin
            r_shift   <= i_data_in;
            r_par_acc <= i_odd_sel;
            r_bit_cnt <= '0;
        end else if (r_state == S_DATA) begin
            r_shift   <= r_shift >> 1;
            r_par_acc <= r_par_acc ^ r_shift[0];
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end else if (r_state == S_PARITY) begin
            r_parity_out <= r_par_acc;
        end
    end

    // Outputs decode from state and datapath registers only, so the async
    // reset forces the line high without waiting for an edge.
    always_comb begin
        o_serial_out = 1'b1;
        o_ser_valid  = 1'b0;
        case (r_state)
`ifdef PARITY_TX_FRAME_EN
            S_START: begin
                o_serial_out = 1'b0;
                o_ser_valid  = 1'b1;
            end
            S_STOP: begin
                o_serial_out = 1'b1;
                o_ser_valid  = 1'b1;
            end
`endif
            S_DATA: begin
                o_serial_out = r_shift[0];
                o_ser_valid  = 1'b1;
            end
            S_PARITY: begin
                o_serial_out = r_par_acc;
                o_ser_valid  = 1'b1;
            end
            default: begin
                o_serial_out = 1'b1;
                o_ser_valid  = 1'b0;
            end
        endcase
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);
    assign o_parity_out = r_parity_out;

endmodule
